// File: rtl/instr_sequencer.sv
`default_nettype none
// instr_sequencer: single-steps or auto-runs through a small program memory, holding
// one instruction word for a coprocessor until it signals completion or times out.
module instr_sequencer #(
  parameter int DEPTH   = 32,
  parameter int LAST    = 29,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        run,
  input  logic        load_en,
  input  logic [4:0]  load_addr,
  input  logic [21:0] load_data,
  input  logic        cop_done,
  output logic [21:0] instr,
  output logic        instr_valid,
  output logic [4:0]  pc,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam int         CW    = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic          step_q;
  logic          run_stop;
  logic [CW-1:0] wait_cnt;
  logic [21:0]   mem [DEPTH];
  logic          step_edge;
  logic          start;
  logic          timeout_hit;
  logic          at_last;

  assign step_edge   = step & ~step_q;
  assign start       = step_edge | (run & ~run_stop);
  assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));
  assign at_last     = (pc == 5'(LAST));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (cop_done || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ISSUE) || (state == WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q      <= 1'b1;  // a step held through reset must not look like an edge
      instr       <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      err         <= 1'b0;
      wait_cnt    <= '0;
      run_stop    <= 1'b0;
    end else begin
      step_q      <= step;
      instr_valid <= (state == ISSUE);
      if (!run) run_stop <= 1'b0;
      if (state == ISSUE) begin
        instr <= mem[pc];
        pc    <= at_last ? 5'd0 : pc + 5'd1;
        if (at_last && run) run_stop <= 1'b1;
      end
      if (state == WAIT && !cop_done) begin
        if (timeout_hit) begin
          err      <= 1'b1;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 1'b1;
        end
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  // Program memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && load_en && load_addr <= 5'(LAST))
      mem[load_addr] <= load_data;
  end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 32: program memory entries.
REQ-002 SHALL have parameter LAST, default 29: highest program index before wrap to 0.
REQ-003 SHALL have parameter TIMEOUT, default 1024: max cycles waiting for cop_done.
REQ-004 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port step  input  1  debounced step button level.
REQ-007 SHALL have port run  input  1  auto-run mode enable.
REQ-008 SHALL have port load_en  input  1  program memory write strobe.
REQ-009 SHALL have port load_addr  input  5  program memory write index.
REQ-010 SHALL have port load_data  input  22  instruction word: N0[21:20], N1[19:12], ID[11:10], LIN[9:7], COL[6:4], OP[3:0].
REQ-011 SHALL have port cop_done  input  1  coprocessor completion pulse.
REQ-012 SHALL have port instr  output  22  instruction held to coprocessor.
REQ-013 SHALL have port instr_valid  output  1  one-cycle pulse when instr changes.
REQ-014 SHALL have port pc  output  5  index of next instruction to issue.
REQ-015 SHALL have port busy  output  1  high in ISSUE and WAIT.
REQ-016 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT.
REQ-018 SHALL detect a step rising edge as step=1 with registered prior step=0.
REQ-019 In IDLE, SHALL go to ISSUE on a step rising edge, or when run=1.
REQ-020 In ISSUE (one cycle), SHALL load instr from mem[pc], pulse instr_valid, advance pc, and enter WAIT.
REQ-021 SHALL advance pc as pc+1, wrapping to 0 when pc=LAST.
REQ-022 SHALL hold instr unchanged outside ISSUE.
REQ-023 In WAIT, SHALL return to IDLE on cop_done=1 and clear the wait counter.
REQ-024 In WAIT, SHALL count cycles; at count=TIMEOUT-1 without cop_done, SHALL set err, return to IDLE, and leave pc as already advanced.
REQ-025 SHALL stop auto-run in IDLE when pc has wrapped to 0 after issuing index LAST; run must drop and reassert to restart.
REQ-026 SHALL ignore step edges outside IDLE and SHALL NOT queue them.
REQ-027 SHALL write mem[load_addr] on load_en only in IDLE; SHALL ignore load_en in ISSUE/WAIT.
REQ-028 SHALL ignore writes with load_addr>LAST.
REQ-029 On simultaneous load_en and step edge in IDLE, SHALL perform both; the ISSUE read next cycle returns the new data if load_addr=pc.
REQ-030 SHALL issue a cop_done arriving in ISSUE as ignored; only WAIT consumes it.
REQ-031 SHALL clear err only on rst.

Reset
REQ-032 On rst=1, SHALL set state=IDLE, instr=0, instr_valid=0, pc=0, busy=0, err=0, wait counter=0, run-stop latch cleared.
REQ-033 On rst, SHALL set the step history register to 1 so that a step held during reset does not trigger.
REQ-034 SHALL NOT reset memory contents.
REQ-035 rst asserted in WAIT or ISSUE SHALL abort the instruction with no further instr_valid.

Verification
REQ-036 Load mem[0]=0x280402 and mem[1]=0x000803; step edge; cop_done 3 cycles later -> instr=0x280402, one instr_valid pulse, pc=1, busy for 4 cycles; second step -> instr=0x000803, pc=2.
REQ-037 With pc=29, step then cop_done -> instr=mem[29], pc=0; run=1 from pc=0 with cop_done 2 cycles after each issue -> exactly 30 instr_valid pulses, then idle with pc=0.
REQ-038 Step, then no cop_done -> err=1 after TIMEOUT cycles in WAIT, state IDLE, pc=1; a subsequent step issues mem[1].
REQ-039 Step held high through rst release -> no issue; a second step edge during WAIT -> ignored, pc unchanged.
REQ-040 load_en with load_addr=0, data 0x000009 during WAIT -> mem[0] unchanged; load_addr=31 in IDLE -> ignored.
REQ-041 rst asserted in the cycle after ISSUE -> busy=0, pc=0, instr=0 next cycle, no instr_valid.
